// File: rtl/rv_dm_wb_if.sv
// Wishbone pipelined bus bundle between the uRV data-memory master and its slave.
interface rv_dm_wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/rv_dm_wb_master.sv
// uRV data-memory master: one Wishbone pipelined bus cycle per load/store strobe,
// with store byte-lane steering, ack/err/timeout handling and completion pulses.
module rv_dm_wb_master #(
    parameter int unsigned g_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] x_dm_data_s_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_err_o,
    output logic        dm_busy_o,
    rv_dm_wb_if.master  wb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The counter holds the number of bus cycles already spent, so the
    // g_timeout-th cycle with cyc high is the last one before aborting.
    localparam logic [15:0] LP_CNT_LAST = 16'(g_timeout - 32'd1);

    state_t      r_state;
    state_t      w_nxt_state;
    logic        w_accept;
    logic        w_done;
    logic        w_err;
    logic        w_timeout;

    logic [29:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [15:0] r_cnt;

    logic [31:0] r_data_l;
    logic        r_load_done;
    logic        r_store_done;
    logic        r_bus_err;

    // Byte enables: loads always read the whole aligned word; stores enable
    // only the lanes of the addressed item; undefined sizes enable nothing.
    function automatic logic [3:0] f_sel(input logic       is_store,
                                         input logic [2:0] fun,
                                         input logic [1:0] a);
        logic [3:0] v_sel;
        v_sel = 4'b0000;
        if (!is_store) begin
            v_sel = 4'b1111;
        end else begin
            case (fun)
                3'b000, 3'b100: v_sel = 4'b0001 << a;
                3'b001, 3'b101: v_sel = a[1] ? 4'b1100 : 4'b0011;
                3'b010:         v_sel = 4'b1111;
                default:        v_sel = 4'b0000;
            endcase
        end
        return v_sel;
    endfunction

    // Write data: replicate the item across all lanes so that the byte
    // enables alone select the destination lane.
    function automatic logic [31:0] f_dat(input logic [2:0]  fun,
                                          input logic [31:0] d);
        logic [31:0] v_dat;
        case (fun)
            3'b000, 3'b100: v_dat = {4{d[7:0]}};
            3'b001, 3'b101: v_dat = {2{d[15:0]}};
            default:        v_dat = d;
        endcase
        return v_dat;
    endfunction

    assign w_timeout = (r_cnt == LP_CNT_LAST);

    // Next-state and completion decode; store wins when both strobes arrive.
    always_comb begin
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (x_store_i || x_load_i) begin
                    w_accept    = 1'b1;
                    w_nxt_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wb.ack || wb.err || w_timeout) begin
                    w_done      = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (!wb.stall) begin
                    w_nxt_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wb.ack || wb.err || w_timeout) begin
                    w_done      = 1'b1;
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        // An ack beats a coincident timeout, but err beats a coincident ack.
        w_err = w_done && (wb.err || !wb.ack);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Latch the request on acceptance; bus fields stay frozen until the next one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_adr <= 30'd0;
            r_dat <= 32'd0;
            r_sel <= 4'd0;
            r_we  <= 1'b0;
        end else if (w_accept) begin
            r_adr <= x_dm_addr_i[31:2];
            r_dat <= f_dat(x_fun_i, x_dm_data_s_i);
            r_sel <= f_sel(x_store_i, x_fun_i, x_dm_addr_i[1:0]);
            r_we  <= x_store_i;
        end
    end

    // Bus-cycle length counter: restarts on acceptance, counts ISSUE/WAIT cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= 16'd0;
        end else if (w_accept) begin
            r_cnt <= 16'd0;
        end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Completion pulses, one cycle after the bus cycle closes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_done  <= w_done && !r_we;
            r_store_done <= w_done && r_we;
            r_bus_err    <= w_err;
        end
    end

    // Load data: the aligned word on ack, zero on a failed load, held otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data_l <= 32'd0;
        end else if (w_done && !r_we) begin
            r_data_l <= w_err ? 32'd0 : wb.dat_r;
        end
    end

    assign wb.cyc = (r_state != ST_IDLE);
    assign wb.stb = (r_state == ST_ISSUE);
    assign wb.we    = r_we;
    assign wb.adr   = {r_adr, 2'b00};
    assign wb.dat_w = r_dat;
    assign wb.sel   = r_sel;

    assign dm_data_l_o     = r_data_l;
    assign dm_load_done_o  = r_load_done;
    assign dm_store_done_o = r_store_done;
    assign dm_bus_err_o    = r_bus_err;
    assign dm_busy_o       = (r_state != ST_IDLE) || r_load_done || r_store_done;

endmodule

// File: tb/tb_rv_dm_wb_master.sv
// Bench for rv_dm_wb_master: directed vector table, timeout/reset sequences,
// and randomized transactions checked against a transaction-level model.
module tb_rv_dm_wb_master;

    localparam int TO_MAIN = 6;
    localparam int TO_SHORT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x_addr;
    logic [31:0] x_data;
    logic [2:0]  x_fun;
    logic        x_load;
    logic        x_store;

    logic [31:0] m_dl;
    logic        m_ld, m_st, m_berr, m_busy;
    logic [31:0] t_dl;
    logic        t_ld, t_st, t_berr, t_busy;

    rv_dm_wb_if wb_m();
    rv_dm_wb_if wb_t();

    // Second instance with a short timeout and a slave that never answers.
    assign wb_t.dat_r = 32'hFFFF_FFFF;
    assign wb_t.ack   = 1'b0;
    assign wb_t.err   = 1'b0;
    assign wb_t.stall = 1'b0;

    rv_dm_wb_master #(.g_timeout(TO_MAIN)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .x_dm_addr_i(x_addr), .x_dm_data_s_i(x_data), .x_fun_i(x_fun),
        .x_load_i(x_load), .x_store_i(x_store),
        .dm_data_l_o(m_dl), .dm_load_done_o(m_ld), .dm_store_done_o(m_st),
        .dm_bus_err_o(m_berr), .dm_busy_o(m_busy),
        .wb(wb_m)
    );

    rv_dm_wb_master #(.g_timeout(TO_SHORT)) dut_to (
        .clk_i(clk), .rst_n_i(rst_n),
        .x_dm_addr_i(x_addr), .x_dm_data_s_i(x_data), .x_fun_i(x_fun),
        .x_load_i(x_load), .x_store_i(x_store),
        .dm_data_l_o(t_dl), .dm_load_done_o(t_ld), .dm_store_done_o(t_st),
        .dm_bus_err_o(t_berr), .dm_busy_o(t_busy),
        .wb(wb_t)
    );

    always #5 clk = ~clk;

    // rsp: 0 none, 1 ack, 2 err, 3 ack+err; rsp_cyc counts bus cycles from 1.
    typedef struct {
        bit          store;
        bit          both;
        logic [2:0]  fun;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        int          rsp;
        int          rsp_cyc;
        logic [31:0] rdata;
        bit          b2b;
        bit          junk;
        bit          e_we;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic [3:0]  e_sel;
        int          e_done;
        bit          e_err;
        logic [31:0] e_dl;
    } txn_t;

    int total = 0;
    int bad = 0;
    int cur_id = 0;
    logic [31:0] model_dl = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, cur_id, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit store, input bit both, input logic [2:0] fun,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int stall, input int rsp, input int rsp_cyc,
                                input logic [31:0] rdata, input bit b2b, input bit junk);
        txn_t t;
        t.store = store; t.both = both; t.fun = fun; t.addr = addr; t.data = data;
        t.stall = stall; t.rsp = rsp; t.rsp_cyc = rsp_cyc; t.rdata = rdata;
        t.b2b = b2b; t.junk = junk;
        t.e_we = 0; t.e_adr = 0; t.e_dat = 0; t.e_sel = 0; t.e_done = 0; t.e_err = 0; t.e_dl = 0;
        return t;
    endfunction

    function automatic txn_t ex(input txn_t t, input bit we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input int done, input bit err, input logic [31:0] dl);
        txn_t r;
        r = t;
        r.e_we = we; r.e_adr = adr; r.e_dat = dat; r.e_sel = sel;
        r.e_done = done; r.e_err = err; r.e_dl = dl;
        return r;
    endfunction

    // Transaction-level model: lanes covered by the naturally aligned item,
    // item bytes repeated across lanes, and end-of-cycle from response vs timeout.
    function automatic txn_t model(input txn_t t, input logic [31:0] prev_dl, input int to);
        txn_t r;
        int size, base, endc;
        bit hit;
        r = t;
        r.e_we = t.store || t.both;
        r.e_adr = t.addr & 32'hFFFF_FFFC;
        r.e_dat = t.data;
        if (!r.e_we) begin
            r.e_sel = 4'hF;
        end else begin
            case (t.fun)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    size = 0;
            endcase
            r.e_sel = 4'h0;
            if (size != 0) begin
                base = (int'(t.addr % 32'd4) / size) * size;
                for (int i = 0; i < 4; i++) begin
                    r.e_sel[i] = (i >= base) && (i < base + size);
                    r.e_dat[8*i +: 8] = t.data[8*(i % size) +: 8];
                end
            end
        end
        hit = (t.rsp != 0) && (t.rsp_cyc <= to);
        endc = hit ? t.rsp_cyc : to;
        r.e_done = endc + 1;
        r.e_err = !(hit && t.rsp == 1);
        r.e_dl = r.e_we ? prev_dl : (r.e_err ? 32'd0 : t.rdata);
        return r;
    endfunction

    task automatic idle_chk();
        @(posedge clk); @(negedge clk);
        chk("idle_cyc", 32'(wb_m.cyc), 32'd0);
        chk("idle_pulses", 32'({m_ld, m_st, m_berr}), 32'd0);
        chk("idle_busy", 32'(m_busy), 32'd0);
    endtask

    // Entered at a negedge with the main instance idle (or in its done cycle).
    task automatic run_txn(input txn_t t);
        x_addr = t.addr; x_data = t.data; x_fun = t.fun;
        x_store = t.store || t.both;
        x_load = !t.store || t.both;
        @(posedge clk); @(negedge clk);
        x_store = 1'b0; x_load = 1'b0;
        for (int k = 1; k < t.e_done; k++) begin
            wb_m.stall = (k <= t.stall);
            wb_m.ack = (t.rsp == 1 || t.rsp == 3) && (k == t.rsp_cyc);
            wb_m.err = (t.rsp == 2 || t.rsp == 3) && (k == t.rsp_cyc);
            wb_m.dat_r = (k == t.rsp_cyc) ? t.rdata : ~t.rdata;
            if (t.junk && k == 1) begin
                x_load = 1'b1; x_store = 1'b1;
            end
            chk("cyc", 32'(wb_m.cyc), 32'd1);
            chk("stb", 32'(wb_m.stb), 32'(k <= t.stall + 1));
            chk("we", 32'(wb_m.we), 32'(t.e_we));
            chk("adr", wb_m.adr, t.e_adr);
            chk("sel", 32'(wb_m.sel), 32'(t.e_sel));
            if (t.e_we && t.e_sel != 4'h0) chk("dat", wb_m.dat_w, t.e_dat);
            chk("early_pulse", 32'({m_ld, m_st, m_berr}), 32'd0);
            chk("busy", 32'(m_busy), 32'd1);
            @(posedge clk); @(negedge clk);
            x_load = 1'b0; x_store = 1'b0;
        end
        wb_m.stall = 1'b0; wb_m.ack = 1'b0; wb_m.err = 1'b0;
        chk("done_cyc", 32'(wb_m.cyc), 32'd0);
        chk("done_stb", 32'(wb_m.stb), 32'd0);
        chk("load_done", 32'(m_ld), 32'(!t.e_we));
        chk("store_done", 32'(m_st), 32'(t.e_we));
        chk("bus_err", 32'(m_berr), 32'(t.e_err));
        chk("data_l", m_dl, t.e_dl);
        chk("done_busy", 32'(m_busy), 32'd1);
    endtask

    txn_t tbl[12];
    txn_t t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        tbl[0]  = ex(mk(1,0,3'd0,32'h1003,32'h0000_00A5,0,1,2,32'h0,0,0), 1,32'h1000,32'hA5A5_A5A5,4'b1000,3,0,32'h0);
        tbl[1]  = ex(mk(1,0,3'd1,32'h2002,32'h0000_1234,0,1,2,32'h0,0,0), 1,32'h2000,32'h1234_1234,4'b1100,3,0,32'h0);
        tbl[2]  = ex(mk(1,0,3'd2,32'h2007,32'hDEAD_BEEF,0,1,2,32'h0,0,1), 1,32'h2004,32'hDEAD_BEEF,4'b1111,3,0,32'h0);
        tbl[3]  = ex(mk(0,0,3'd0,32'h3001,32'h0,3,1,5,32'hCAFE_BABE,0,0), 0,32'h3000,32'h0,4'b1111,6,0,32'hCAFE_BABE);
        tbl[4]  = ex(mk(0,0,3'd2,32'h4000,32'h0,0,2,2,32'h1111_1111,0,0), 0,32'h4000,32'h0,4'b1111,3,1,32'h0);
        tbl[5]  = ex(mk(1,1,3'd2,32'h5000,32'h0102_0304,0,1,2,32'h0,0,0), 1,32'h5000,32'h0102_0304,4'b1111,3,0,32'h0);
        tbl[6]  = ex(mk(0,0,3'd5,32'h6002,32'h0,0,1,6,32'h89AB_CDEF,0,0), 0,32'h6000,32'h0,4'b1111,7,0,32'h89AB_CDEF);
        tbl[7]  = ex(mk(1,0,3'd3,32'h7001,32'hCAFE_0001,0,1,2,32'h0,0,0), 1,32'h7000,32'h0,4'b0000,3,0,32'h89AB_CDEF);
        tbl[8]  = ex(mk(0,0,3'd2,32'h8000,32'h0,0,3,1,32'h2222_2222,0,0), 0,32'h8000,32'h0,4'b1111,2,1,32'h0);
        tbl[9]  = ex(mk(1,0,3'd1,32'h9001,32'hFFFF_8001,0,1,3,32'h0,1,1), 1,32'h9000,32'h8001_8001,4'b0011,4,0,32'h0);
        tbl[10] = ex(mk(0,0,3'd2,32'hA004,32'h0,0,0,1,32'h3333_3333,1,0), 0,32'hA004,32'h0,4'b1111,7,1,32'h0);
        tbl[11] = ex(mk(1,0,3'd0,32'hB002,32'h1234_5677,1,1,1,32'h0,0,0), 1,32'hB000,32'h7777_7777,4'b0100,2,0,32'h0);

        rst_n = 1'b0;
        x_addr = 32'd0; x_data = 32'd0; x_fun = 3'd0; x_load = 1'b0; x_store = 1'b0;
        wb_m.dat_r = 32'd0; wb_m.ack = 1'b0; wb_m.err = 1'b0; wb_m.stall = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb_m.cyc), 32'd0);
        chk("rst_stb", 32'(wb_m.stb), 32'd0);
        chk("rst_bus", 32'({wb_m.we, wb_m.sel}), 32'd0);
        chk("rst_adr", wb_m.adr, 32'd0);
        chk("rst_dat", wb_m.dat_w, 32'd0);
        chk("rst_pulses", 32'({m_ld, m_st, m_berr, m_busy}), 32'd0);
        chk("rst_dl", m_dl, 32'd0);
        rst_n = 1'b1;
        idle_chk();

        for (int i = 0; i < 12; i++) begin
            cur_id = i;
            if (!tbl[i].b2b) idle_chk();
            run_txn(tbl[i]);
        end
        idle_chk();
        model_dl = tbl[11].e_dl;

        // Short-timeout instance: cyc for exactly TO_SHORT cycles, then done+err.
        cur_id = 100;
        repeat (6) idle_chk();
        x_addr = 32'hE000; x_fun = 3'd2; x_load = 1'b1;
        @(posedge clk); @(negedge clk);
        x_load = 1'b0;
        for (int k = 1; k <= TO_SHORT; k++) begin
            chk("to_cyc", 32'(wb_t.cyc), 32'd1);
            if (k == 1) chk("to_stb", 32'(wb_t.stb), 32'd1);
            chk("to_early", 32'({t_ld, t_berr}), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("to_cyc_drop", 32'(wb_t.cyc), 32'd0);
        chk("to_done", 32'({t_ld, t_st}), 32'b10);
        chk("to_err", 32'(t_berr), 32'd1);
        chk("to_dl", t_dl, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("to_pulse_once", 32'(t_ld), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("main_to_done", 32'({m_ld, m_berr}), 32'b11);
        model_dl = 32'd0;
        idle_chk();

        // Reset while waiting for ack.
        cur_id = 200;
        t = model(mk(0,0,3'd2,32'hC000,32'h0,0,1,2,32'h5A5A_5A5A,0,0), model_dl, TO_MAIN);
        run_txn(t);
        idle_chk();
        x_addr = 32'hD000; x_fun = 3'd2; x_load = 1'b1;
        @(posedge clk); @(negedge clk);
        x_load = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wait_cyc", 32'(wb_m.cyc), 32'd1);
        chk("wait_stb", 32'(wb_m.stb), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'({wb_m.cyc, wb_m.stb}), 32'd0);
        chk("arst_bus", 32'({wb_m.we, wb_m.sel}), 32'd0);
        chk("arst_adr", wb_m.adr, 32'd0);
        chk("arst_out", 32'({m_ld, m_st, m_berr, m_busy}), 32'd0);
        chk("arst_dl", m_dl, 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_chk();
        model_dl = 32'd0;
        t = model(mk(1,0,3'd1,32'hD003,32'h0000_BEEF,1,1,3,32'h0,0,0), model_dl, TO_MAIN);
        cur_id = 201;
        run_txn(t);
        idle_chk();

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            cur_id = 300 + i;
            t = mk(bit'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0),
                   3'($urandom_range(7, 0)), $urandom(), $urandom(),
                   int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(8, 1)), $urandom(),
                   bit'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
            t = model(t, model_dl, TO_MAIN);
            if (!t.b2b) idle_chk();
            run_txn(t);
            model_dl = t.e_dl;
        end
        idle_chk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_dm_wb_master.md
# rv_dm_wb_master

Data-memory master for the uRV core: accepts one load or store request per strobe from the execute stage, runs a single Wishbone pipelined bus cycle, and returns load data plus load/store completion pulses to the writeback stage. It is the producer of `dm_data_l`, `dm_load_done` and `dm_store_done`. It also owns store byte-lane steering, which writeback does not do. Load data is returned as the full aligned word; writeback extracts and sign-extends it.

## Interface
- `g_timeout`, 255: bus cycles to wait for ack/err before aborting; legal range 1..65535.

- `clk_i` in 1: core clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `x_dm_addr_i` in 32: byte address of the request.
- `x_dm_data_s_i` in 32: unaligned store data (rs2 value).
- `x_fun_i` in 3: access size, RISC-V funct3: B=000, H=001, L=010, BU=100, HU=101.
- `x_load_i` in 1: one-cycle load request strobe.
- `x_store_i` in 1: one-cycle store request strobe.
- `dm_data_l_o` out 32: raw aligned word read by the last completed load.
- `dm_load_done_o` out 1: one-cycle pulse, load complete.
- `dm_store_done_o` out 1: one-cycle pulse, store complete.
- `dm_bus_err_o` out 1: one-cycle pulse, coincident with the done pulse, when the access ended by `wb_err_i` or timeout.
- `dm_busy_o` out 1: high from the cycle after an accepted strobe until the done pulse, inclusive.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_stb_o` out 1: Wishbone strobe.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_adr_o` out 32: Wishbone address, `{addr[31:2],2'b00}`.
- `wb_dat_o` out 32: Wishbone write data.
- `wb_sel_o` out 4: Wishbone byte select.
- `wb_dat_i` in 32: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.
- `wb_stall_i` in 1: Wishbone pipelined stall.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - A strobe latches address, fun, store data and direction, then moves to ISSUE.
  - If both strobes are high, the store is taken and the load is ignored.
  - Strobes received outside IDLE are ignored.
- **ISSUE**
  - `cyc`=`stb`=1.
  - If `wb_stall_i`=0, drop `stb` and go to WAIT.
  - `ack`/`err` seen in ISSUE completes the access directly.
- **WAIT**
  - `cyc`=1, `stb`=0, until `ack` or `err`.
- **Completion**
  - On `ack`/`err`/timeout: `cyc`=0, return to IDLE.
  - Next cycle: pulse `dm_load_done_o` or `dm_store_done_o`.
  - For a load ending in ack, register `wb_dat_i` into `dm_data_l_o`.
  - For a load ending in err or timeout, `dm_data_l_o` is 0.
  - `dm_data_l_o` holds its value until the next load completes; store completion leaves it unchanged.
- **Store steering**
  - B: `dat`={4{d[7:0]}}, `sel`=4'b0001<<addr[1:0].
  - H: `dat`={2{d[15:0]}}, `sel`=addr[1]?4'b1100:4'b0011.
  - L: `dat`=d, `sel`=4'b1111.
  - `addr[0]` is ignored for H; `addr[1:0]` is ignored for L.
- **Loads**: `sel`=4'b1111 and `we`=0 regardless of fun.
- **Undefined fun** (011, 110, 111) on a store: `sel`=4'b0000. The bus cycle still runs and completes normally.
- **Timeout counter**
  - Cleared on leaving IDLE; increments each ISSUE/WAIT cycle.
  - When the counter equals `g_timeout` without ack/err: abort, report error.
  - `ack` arriving in the same cycle as the timeout wins (normal completion).
  - `ack` and `err` together: treated as err.

## Timing
- **Reset**: every output 0, FSM IDLE, counter 0, latched request cleared. Reset mid-access drops `cyc`/`stb` immediately and produces no done pulse.
- **Best-case latency**: strobe in cycle 0; `stb` high in cycle 1; `ack` in cycle 2; done pulse and data valid in cycle 3.
- Each wb_stall_i cycle in ISSUE and each ack-wait cycle adds one cycle.
- **Outputs held stable while `stb`=1 and stalled**: `wb_adr_o`, `wb_dat_o`, `wb_sel_o`, `wb_we_o`.
- Exactly one bus cycle and exactly one done pulse per accepted strobe.
- **Back-to-back**: a strobe arriving in the done-pulse cycle is accepted (FSM already IDLE). Its `stb` rises the next cycle.

## Test plan
- **Store byte**: SB addr=0x1003, data=0x000000A5, no stall, ack next cycle.
  - Bus: adr=0x1000, dat=0xA5A5A5A5, sel=1000, we=1.
  - `dm_store_done_o` pulses in cycle 3.
- **Store half / word**: SH addr=0x2002, data=0x1234 -> dat=0x12341234, sel=1100. SW addr=0x2007 -> adr=0x2004, sel=1111.
- **Load with stall**: LB addr=0x3001, `wb_stall_i` high 3 cycles, ack with 0xCAFEBABE.
  - adr/sel stable during stall.
  - `dm_load_done_o` in cycle 6, `dm_data_l_o`=0xCAFEBABE.
- **Error and timeout**:
  - `wb_err_i` on a load -> done + `dm_bus_err_o` together, data 0.
  - `g_timeout`=4, never ack -> `cyc` drops after 4 cycles, done + err pulse.
- **Arbitration and back-to-back**:
  - Load and store strobes together -> only the store is issued.
  - Strobe while busy -> ignored.
  - New strobe in the done cycle -> issued immediately after.
- **Reset**: assert `rst_n_i` while in WAIT -> `cyc`=0 at once, no done pulse, all outputs 0. Next request after release completes normally.
